// File: rtl/change_payout_if.sv
// Handshake, tube-status and hopper signals between the vending core, the
// payout controller and the coin hopper.
interface change_payout_if;
    logic       change_valid_i;
    logic [4:0] change_i;
    logic       change_ready_o;
    logic       nickel_empty_i;
    logic       dime_empty_i;
    logic       quarter_empty_i;
    logic       coin_req_o;
    logic [1:0] coin_sel_o;
    logic       coin_ack_i;
    logic       busy_o;
    logic       done_o;
    logic       short_o;
    logic       timeout_o;
    logic [4:0] remain_o;

    modport slave (
        input  change_valid_i, change_i, nickel_empty_i, dime_empty_i,
               quarter_empty_i, coin_ack_i,
        output change_ready_o, coin_req_o, coin_sel_o, busy_o, done_o,
               short_o, timeout_o, remain_o
    );

    modport master (
        output change_valid_i, change_i, nickel_empty_i, dime_empty_i,
               quarter_empty_i, coin_ack_i,
        input  change_ready_o, coin_req_o, coin_sel_o, busy_o, done_o,
               short_o, timeout_o, remain_o
    );
endinterface

// File: rtl/change_payout_ctrl.sv
// Coin hopper payout sequencer: greedy largest-coin-first change payout with
// empty-tube fallback, shortfall reporting and hopper ack timeout.
//
// state  | meaning
// IDLE   | ready for a new change amount
// SELECT | pick the largest coin that fits and is stocked
// REQ    | coin request held until ack or timeout
// DONE   | one-cycle completion pulse with short/timeout flags
module change_payout_ctrl #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    change_payout_if.slave bus
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] SEL_NICKEL  = 2'b00;
    localparam logic [1:0] SEL_DIME    = 2'b01;
    localparam logic [1:0] SEL_QUARTER = 2'b10;

    typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

    state_t        state_q, state_d;
    logic [4:0]    remain_q, remain_d;
    logic [1:0]    sel_q, sel_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          short_q, short_d;
    logic          timeout_q, timeout_d;
    logic [4:0]    coin_val;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            sel_q     <= SEL_NICKEL;
            tmr_q     <= '0;
            short_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            sel_q     <= sel_d;
            tmr_q     <= tmr_d;
            short_q   <= short_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        case (sel_q)
            SEL_QUARTER: coin_val = 5'd25;
            SEL_DIME:    coin_val = 5'd10;
            default:     coin_val = 5'd5;
        endcase
    end

    // short/timeout default low so they are only ever high during DONE
    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        sel_d     = sel_q;
        tmr_d     = tmr_q;
        short_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.change_valid_i) begin
                    remain_d = bus.change_i;
                    state_d  = SELECT;
                end
            end
            SELECT: begin
                tmr_d = TMR_LOAD;
                if (remain_q >= 5'd25 && !bus.quarter_empty_i) begin
                    sel_d   = SEL_QUARTER;
                    state_d = REQ;
                end else if (remain_q >= 5'd10 && !bus.dime_empty_i) begin
                    sel_d   = SEL_DIME;
                    state_d = REQ;
                end else if (remain_q >= 5'd5 && !bus.nickel_empty_i) begin
                    sel_d   = SEL_NICKEL;
                    state_d = REQ;
                end else begin
                    short_d = (remain_q != 5'd0);
                    state_d = DONE;
                end
            end
            REQ: begin
                if (bus.coin_ack_i) begin
                    remain_d = remain_q - coin_val;
                    state_d  = SELECT;
                end else if (tmr_q == '0) begin
                    short_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.change_ready_o = (state_q == IDLE);
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.coin_req_o     = (state_q == REQ);
    assign bus.coin_sel_o     = sel_q;
    assign bus.done_o         = (state_q == DONE);
    assign bus.short_o        = short_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.remain_o       = remain_q;
endmodule

// File: tb/tb_change_payout_ctrl.sv
// Scoreboard bench for change_payout_ctrl: directed payouts plus random
// amounts, tube states and hopper ack delays checked against a greedy model.
module tb_change_payout_ctrl;
    localparam int ACK = 15;

    typedef struct {
        int rem;
        bit sh;
        bit to;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    change_payout_if dif();

    change_payout_ctrl #(.ACK_TIMEOUT(ACK)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   req_len = 0;
    bit   mon_en = 0;
    bit   prev_req = 0;
    int   ack_delay = 0;
    bit   ack_never = 0;
    int   seen = 0;
    exp_t exp_q[$];
    int   coin_q[$];

    always @(negedge clk) cyc++;

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // hopper: acks the request after ack_delay extra REQ cycles
    always @(posedge clk) begin
        #1;
        if (dif.coin_req_o && !ack_never) begin
            dif.coin_ack_i = (seen == ack_delay);
            seen++;
        end else begin
            dif.coin_ack_i = 1'b0;
            seen = 0;
        end
    end

    // monitor: pops expected coins on each new request and results on done
    always @(posedge clk) begin
        exp_t e;
        int   s;
        #1;
        if (mon_en) begin
            if (dif.coin_req_o) begin
                if (!prev_req) begin
                    req_len = 1;
                    if (coin_q.size() == 0) begin
                        check("unexpected_req", 1, 0);
                    end else begin
                        s = coin_q.pop_front();
                        check("coin_sel", int'(dif.coin_sel_o), s);
                    end
                end else begin
                    req_len++;
                end
            end
            if (dif.done_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("remain", int'(dif.remain_o), e.rem);
                    check("short", int'(dif.short_o), int'(e.sh));
                    check("timeout", int'(dif.timeout_o), int'(e.to));
                    check("latency", cyc - acc_cyc, e.lat);
                    check("coins_left", coin_q.size(), 0);
                    if (e.to) check("req_len", req_len, ACK);
                end
            end else begin
                check("flags_quiet", int'({dif.short_o, dif.timeout_o}), 0);
            end
            prev_req = dif.coin_req_o;
        end
    end

    // greedy reference: pays the largest stocked coin that fits, repeatedly
    task automatic model(int amt, bit ne, bit de, bit qe, int d, bit never);
        exp_t e;
        int rem = amt;
        int n = 0;
        int c;
        int code;
        e.to = 0;
        for (int k = 0; k < 8; k++) begin
            c = 0;
            code = 0;
            if (rem >= 25 && !qe) begin c = 25; code = 2; end
            else if (rem >= 10 && !de) begin c = 10; code = 1; end
            else if (rem >= 5 && !ne) begin c = 5; code = 0; end
            if (c == 0) break;
            coin_q.push_back(code);
            if (never) begin e.to = 1; break; end
            rem -= c;
            n++;
        end
        e.rem = rem;
        e.sh  = e.to || (rem != 0);
        e.lat = e.to ? 1 + ACK : n * (d + 2) + 1;
        exp_q.push_back(e);
    endtask

    task automatic payout(int amt, bit ne, bit de, bit qe, int d, bit never);
        int k;
        dif.nickel_empty_i  = ne;
        dif.dime_empty_i    = de;
        dif.quarter_empty_i = qe;
        ack_delay = d;
        ack_never = never;
        model(amt, ne, de, qe, d, never);
        check("ready_before_accept", int'(dif.change_ready_o), 1);
        dif.change_i = 5'(amt);
        dif.change_valid_i = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        dif.change_valid_i = 1'b0;
        k = 0;
        while (!dif.done_o && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!dif.done_o) begin
            check("done_wait", 0, 1);
            exp_q.delete();
            coin_q.delete();
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int k;
        dif.change_valid_i  = 1'b0;
        dif.change_i        = '0;
        dif.nickel_empty_i  = 1'b0;
        dif.dime_empty_i    = 1'b0;
        dif.quarter_empty_i = 1'b0;
        dif.coin_ack_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(dif.change_ready_o), 1);
        check("rst_busy", int'(dif.busy_o), 0);
        check("rst_req", int'(dif.coin_req_o), 0);
        check("rst_sel", int'(dif.coin_sel_o), 0);
        check("rst_done", int'(dif.done_o), 0);
        check("rst_flags", int'({dif.short_o, dif.timeout_o}), 0);
        check("rst_remain", int'(dif.remain_o), 0);
        rst_n = 1'b1;
        mon_en = 1;

        payout(20, 0, 0, 0, 0, 0);
        payout(30, 0, 0, 0, 1, 0);
        payout(15, 0, 1, 0, 0, 0);
        payout(7,  0, 0, 0, 2, 0);
        payout(10, 1, 1, 1, 0, 0);
        payout(25, 0, 0, 0, 0, 1);
        payout(0,  0, 0, 0, 0, 0);
        payout(31, 0, 0, 0, 3, 0);

        // reset while a quarter request is outstanding
        dif.nickel_empty_i  = 1'b0;
        dif.dime_empty_i    = 1'b0;
        dif.quarter_empty_i = 1'b0;
        ack_never = 1;
        coin_q.push_back(2);
        dif.change_i = 5'd30;
        dif.change_valid_i = 1'b1;
        @(posedge clk); #1;
        dif.change_valid_i = 1'b0;
        k = 0;
        while (!dif.coin_req_o && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("req_before_reset", int'(dif.coin_req_o), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_req", int'(dif.coin_req_o), 0);
        check("mid_rst_busy", int'(dif.busy_o), 0);
        check("mid_rst_ready", int'(dif.change_ready_o), 1);
        check("mid_rst_remain", int'(dif.remain_o), 0);
        coin_q.delete();
        payout(10, 0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            payout(int'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
